// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon button front end.
// Colour codes double as button indices; lowest index has priority.
package simon_pkg;

    typedef logic [1:0] simon_color_t;

    localparam simon_color_t SIMON_TL = 2'd0;
    localparam simon_color_t SIMON_TR = 2'd1;
    localparam simon_color_t SIMON_BL = 2'd2;
    localparam simon_color_t SIMON_BR = 2'd3;

    localparam int SIMON_DEBOUNCE_DEFAULT = 1000000;

    // Lowest set bit wins; an all-zero vector maps to TL (code 0).
    function automatic simon_color_t simon_first_set(input logic [3:0] vec);
        simon_color_t c;
        c = SIMON_TL;
        if (vec[0])      c = SIMON_TL;
        else if (vec[1]) c = SIMON_TR;
        else if (vec[2]) c = SIMON_BL;
        else if (vec[3]) c = SIMON_BR;
        return c;
    endfunction

endpackage

// File: rtl/simon_debounce.sv
// Single-button conditioner: 2-flop synchroniser on the active-low pad,
// then a counter that accepts a new level after DEBOUNCE_CYCLES agreeing cycles.
module simon_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic pressed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             synced;

    assign synced = ~sync2_q;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pressed_o = stable_q;

endmodule

// File: rtl/simon_btn_input.sv
// Simon button input conditioner: four debounced buttons, live held colour,
// and a single-entry press-event buffer. Optional SIMON_BTN_RELEASE_EN adds release events.
module simon_btn_input
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIMON_DEBOUNCE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_tl_n,
    input  logic         btn_tr_n,
    input  logic         btn_bl_n,
    input  logic         btn_br_n,
    output logic         held,
    output logic [1:0]   held_color,
    output logic         press_valid,
    output logic [1:0]   press_color,
    input  logic         press_ack,
`ifdef SIMON_BTN_RELEASE_EN
    output logic         press_is_release,
`endif
    output logic         press_overflow
);

    logic [3:0]   pads_n;
    logic [3:0]   stable;
    logic [3:0]   prev_q;
    logic [3:0]   rise;
    logic         ev_valid;
    simon_color_t ev_color;
    logic         valid_q, valid_d;
    simon_color_t color_q, color_d;
    logic         ovf_q, ovf_d;

    assign pads_n = {btn_br_n, btn_bl_n, btn_tr_n, btn_tl_n};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        simon_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .btn_n_i  (pads_n[i]),
            .pressed_o(stable[i])
        );
    end

    assign held       = |stable;
    assign held_color = simon_first_set(stable);
    assign rise       = stable & ~prev_q;

`ifdef SIMON_BTN_RELEASE_EN
    logic [3:0] fall;
    logic       ev_rel;
    logic       rel_q, rel_d;

    assign fall = ~stable & prev_q;

    // A press in the same cycle as a release takes precedence.
    always_comb begin
        ev_valid = |rise;
        ev_color = simon_first_set(rise);
        ev_rel   = 1'b0;
        if (!(|rise) && (|fall)) begin
            ev_valid = 1'b1;
            ev_color = simon_first_set(fall);
            ev_rel   = 1'b1;
        end
    end
`else
    always_comb begin
        ev_valid = |rise;
        ev_color = simon_first_set(rise);
    end
`endif

    // Single-entry buffer: an ack frees the slot in the same cycle a new event lands.
    always_comb begin
        valid_d = valid_q;
        color_d = color_q;
        ovf_d   = 1'b0;
`ifdef SIMON_BTN_RELEASE_EN
        rel_d   = rel_q;
`endif
        if (ev_valid) begin
            if (!valid_q || press_ack) begin
                valid_d = 1'b1;
                color_d = ev_color;
`ifdef SIMON_BTN_RELEASE_EN
                rel_d   = ev_rel;
`endif
            end else begin
                ovf_d = 1'b1;
            end
        end else if (press_ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= '0;
            valid_q <= 1'b0;
            color_q <= SIMON_TL;
            ovf_q   <= 1'b0;
`ifdef SIMON_BTN_RELEASE_EN
            rel_q   <= 1'b0;
`endif
        end else begin
            prev_q  <= stable;
            valid_q <= valid_d;
            color_q <= color_d;
            ovf_q   <= ovf_d;
`ifdef SIMON_BTN_RELEASE_EN
            rel_q   <= rel_d;
`endif
        end
    end

    assign press_valid    = valid_q;
    assign press_color    = color_q;
    assign press_overflow = ovf_q;
`ifdef SIMON_BTN_RELEASE_EN
    assign press_is_release = rel_q;
`endif

endmodule
